// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution plus a direct-mapped table of saturating direction counters.
// Optional macro BPU_STATS_EN adds branch and mispredict event counters.
module branch_predict_unit #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [2:0]      ex_func3,
    input  logic            zf,
    input  logic            ltf,
    input  logic            ltuf,
    input  logic            ex_pred_taken,
    output logic            take_branch,
`ifdef BPU_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            mispredict
);

    localparam int unsigned Depth = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] CtrRst = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CtrMax = {CTR_W{1'b1}};

    logic [CTR_W-1:0]   ctr_q [Depth];
    logic [CTR_W-1:0]   ctr_d [Depth];
    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic               branch_vld;
    logic               func3_legal;
    logic               take_raw;
    logic               upd_en;
    logic [CTR_W-1:0]   ctr_cur;
    logic [CTR_W-1:0]   ctr_upd;

    assign if_idx = if_pc[INDEX_W+1:2];
    assign ex_idx = ex_pc[INDEX_W+1:2];

    // Tag bits and byte offset do not participate in indexing.
    logic unused_pc;
    assign unused_pc = ^{if_pc[PC_W-1:INDEX_W+2], if_pc[1:0],
                         ex_pc[PC_W-1:INDEX_W+2], ex_pc[1:0]};

    always_comb begin
        take_raw    = 1'b0;
        func3_legal = 1'b1;
        case (ex_func3)
            3'b000:  take_raw = zf;
            3'b001:  take_raw = !zf;
            3'b100:  take_raw = ltf;
            3'b101:  take_raw = !ltf;
            3'b110:  take_raw = ltuf;
            3'b111:  take_raw = !ltuf;
            default: func3_legal = 1'b0;
        endcase
    end

    assign branch_vld    = ex_valid & ex_branch;
    assign take_branch   = branch_vld & take_raw;
    // A non-branch that aliased onto a taken entry must also be redirected (to pc+4).
    assign mispredict    = ex_valid & ((ex_branch & (take_branch != ex_pred_taken)) |
                                       (!ex_branch & ex_pred_taken));
    assign if_pred_taken = !rst & ctr_q[if_idx][CTR_W-1];
    assign upd_en        = branch_vld & func3_legal;
    assign ctr_cur       = ctr_q[ex_idx];

    always_comb begin
        ctr_upd = ctr_cur;
        if (take_branch) begin
            if (ctr_cur != CtrMax) ctr_upd = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_W'(1);
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) ctr_d[ex_idx] = ctr_upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) ctr_q[i] <= CtrRst;
        end else begin
            ctr_q <= ctr_d;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (branch_vld) stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against an integer-array reference model.
// Define BPU_STATS_EN to also check the event counters.
module tb_branch_predict_unit;

    localparam int PC_W    = 32;
    localparam int INDEX_W = 6;
    localparam int CTR_W   = 2;
    localparam int DEPTH   = 2 ** INDEX_W;
    localparam int CMAX    = 2 ** CTR_W - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_branch;
    logic [PC_W-1:0] ex_pc;
    logic [2:0]      ex_func3;
    logic            zf, ltf, ltuf;
    logic            ex_pred_taken;
    logic            take_branch;
    logic            mispredict;
`ifdef BPU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_predict_unit #(
        .PC_W   (PC_W),
        .INDEX_W(INDEX_W),
        .CTR_W  (CTR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_pred_taken(if_pred_taken),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_pc        (ex_pc),
        .ex_func3     (ex_func3),
        .zf           (zf),
        .ltf          (ltf),
        .ltuf         (ltuf),
        .ex_pred_taken(ex_pred_taken),
        .take_branch  (take_branch),
`ifdef BPU_STATS_EN
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .mispredict   (mispredict)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ref_ctr [DEPTH];
    int ref_br  = 0;
    int ref_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [PC_W-1:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit legal_f3(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic bit ref_take(input logic [2:0] f3, input bit z, input bit lt,
                                    input bit ltu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs are set by the caller just after a falling edge; this checks the
    // combinational outputs, clocks once, advances the model and checks state.
    task automatic step();
        bit exp_take, exp_mis, exp_pred;
        int ei;
        ei       = idx_of(ex_pc);
        exp_take = ex_valid && ex_branch && ref_take(ex_func3, zf, ltf, ltuf);
        exp_mis  = ex_valid && (ex_branch ? (exp_take != ex_pred_taken) : ex_pred_taken);
        exp_pred = !rst && (ref_ctr[idx_of(if_pc)] >= 2 ** (CTR_W - 1));
        #2;
        check("if_pred_taken", 32'(if_pred_taken), 32'(exp_pred));
        check("take_branch", 32'(take_branch), 32'(exp_take));
        check("mispredict", 32'(mispredict), 32'(exp_mis));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_ctr[i] = 2 ** (CTR_W - 1) - 1;
            ref_br  = 0;
            ref_mis = 0;
        end else begin
            if (ex_valid && ex_branch && legal_f3(ex_func3)) begin
                if (exp_take) ref_ctr[ei] = (ref_ctr[ei] == CMAX) ? CMAX : ref_ctr[ei] + 1;
                else          ref_ctr[ei] = (ref_ctr[ei] == 0) ? 0 : ref_ctr[ei] - 1;
            end
            ref_br  += int'(ex_valid && ex_branch);
            ref_mis += int'(exp_mis);
        end
        #1;
        check("ctr_entry", 32'(dut.ctr_q[ei]), 32'(ref_ctr[ei]));
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, 32'(ref_br));
        check("stat_mispredicts", stat_mispredicts, 32'(ref_mis));
`endif
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; ex_valid = 0; ex_branch = 0; ex_func3 = 0; ex_pc = 0;
        zf = 0; ltf = 0; ltuf = 0; ex_pred_taken = 0; if_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic resolve(input logic [PC_W-1:0] pc, input logic [2:0] f3, input bit z,
                           input bit pred);
        ex_valid = 1; ex_branch = 1; ex_pc = pc; ex_func3 = f3;
        zf = z; ltf = $urandom_range(1); ltuf = $urandom_range(1);
        ex_pred_taken = pred;
        step();
    endtask

    int legal_list [6] = '{0, 1, 4, 5, 6, 7};

    initial begin
        idle_inputs();
        @(negedge clk);
        // Reset with random traffic on the EX side; prediction must read 0.
        rst = 1; ex_valid = 1; ex_branch = 1; ex_func3 = 3'd0; zf = 1;
        ex_pred_taken = 0; if_pc = 32'h100;
        for (int i = 0; i < DEPTH; i++) ref_ctr[i] = 2 ** (CTR_W - 1) - 1;
        step();
        idle_inputs();

        if_pc = 32'h40;
        step();
        check("reset_ctr16", 32'(dut.ctr_q[16]), 32'd1);

        resolve(32'h200, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int f = 0; f < 2; f++) begin
                ex_valid = 1; ex_branch = 1; ex_pc = 32'(($urandom_range(63)) << 2);
                ex_func3 = 3'(legal_list[k]);
                zf = f[0]; ltf = f[0]; ltuf = f[0];
                ex_pred_taken = $urandom_range(1);
                if_pc = $urandom;
                step();
            end
        end

        // Training at 0x100 while IF looks at the same entry: same-cycle read is pre-update.
        do_reset();
        if_pc = 32'h100;
        for (int i = 0; i < 4; i++) resolve(32'h100, 3'd0, 1'b1, 1'b0);
        check("train_sat_hi", 32'(dut.ctr_q[0]), 32'd3);
        for (int i = 0; i < 4; i++) resolve(32'h100, 3'd1, 1'b1, 1'b1);
        check("train_sat_lo", 32'(dut.ctr_q[0]), 32'd0);

        do_reset();
        if_pc = 32'h100;
        resolve(32'h100, 3'd0, 1'b1, 1'b0);
        idle_inputs();
        if_pc = 32'h100;
        step();

        // Illegal func3 and aliased non-branch: mispredict without training.
        resolve(32'h100, 3'd2, 1'b1, 1'b1);
        ex_valid = 1; ex_branch = 0; ex_pc = 32'h100; ex_pred_taken = 1;
        step();
        check("no_update", 32'(dut.ctr_q[0]), 32'd2);

        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(39) == 0);
            ex_valid      = $urandom_range(3) != 0;
            ex_branch     = $urandom_range(3) != 0;
            ex_pc         = $urandom;
            ex_func3      = 3'($urandom_range(7));
            zf            = $urandom_range(1);
            ltf           = $urandom_range(1);
            ltuf          = $urandom_range(1);
            ex_pred_taken = $urandom_range(1);
            if_pc         = $urandom_range(1) ? ex_pc : 32'($urandom);
            step();
        end

`ifdef BPU_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) resolve(32'h300, 3'd0, 1'b1, i >= 3);
        check("stats_br_10", stat_branches, 32'd10);
        check("stats_mis_3", stat_mispredicts, 32'd3);
        ex_valid = 1; ex_branch = 1; ex_pc = 32'h304; ex_func3 = 3'd0; zf = 1;
        ex_pred_taken = 0; rst = 1;
        step();
        rst = 0;
        check("stats_br_rst", stat_branches, 32'd0);
        check("stats_mis_rst", stat_mispredicts, 32'd0);
        check("rst_discard", 32'(dut.ctr_q[1]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch decision logic.
- Combines BEQ/BNE/BLT/BGE/BLTU/BGEU resolution with a direct-mapped table of saturating counters.
- Predicts the branch direction at fetch and updates the predictor at resolution.
- Sits between IF (prediction lookup) and EX (resolution); flags mispredictions to the hazard/flush logic.

Parameters:
- PC_W, 32, width of PC inputs.
- INDEX_W, 6, table index bits; table depth = 2**INDEX_W entries.
- CTR_W, 2, saturating counter width (legal range 1..4).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_pc  input  PC_W  PC of instruction being fetched
- if_pred_taken  output  1  prediction for if_pc (combinational table read)
- ex_valid  input  1  EX stage holds a valid instruction
- ex_branch  input  1  EX instruction is a conditional branch
- ex_pc  input  PC_W  PC of EX instruction
- ex_func3  input  3  branch condition field
- zf  input  1  ALU zero flag
- ltf  input  1  ALU signed less-than flag
- ltuf  input  1  ALU unsigned less-than flag
- ex_pred_taken  input  1  prediction carried down the pipeline with the EX instruction
- take_branch  output  1  resolved direction (combinational)
- mispredict  output  1  EX prediction was wrong; flush IF/ID, redirect PC (combinational)

Behaviour:
- Index = pc[INDEX_W+1:2] for both if_pc and ex_pc; pc[1:0] ignored.
- Table: 2**INDEX_W counters of CTR_W bits. Reset value = 2**(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2). All entries are reset in the single rst cycle.
- if_pred_taken = MSB of counter[index(if_pc)]. Pure table read, no latency. Forced to 0 while rst=1.
- Resolution when ex_valid & ex_branch:
  - 000: take = zf
  - 001: take = !zf
  - 100: take = ltf
  - 101: take = !ltf
  - 110: take = ltuf
  - 111: take = !ltuf
  - 010/011 (illegal): take = 0.
- take_branch = 0 whenever !(ex_valid & ex_branch).
- mispredict = ex_valid & ( (ex_branch & (take_branch != ex_pred_taken)) | (!ex_branch & ex_pred_taken) ). The second term covers an aliased non-branch predicted taken; the redirect target is then pc+4.
- Update, registered on the next rising edge, when ex_valid & ex_branch & legal func3 & !rst:
  - taken: counter += 1, saturating at 2**CTR_W-1.
  - not taken: counter -= 1, saturating at 0.
- No update for non-branches, illegal func3, or ex_valid=0.
- Same-cycle IF read and EX write to the same index: IF sees the pre-update value (no bypass). The new value is visible from the next cycle.
- rst asserted mid-operation: the update in that cycle is discarded; table returns to reset values; combinational outputs follow inputs except if_pred_taken=0.
- Saturation: increment at max and decrement at 0 leave the counter unchanged (no wrap).

Optional Feature:
- Macro BPU_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0], both reset to 0.
  - stat_branches increments on each cycle with ex_valid & ex_branch.
  - stat_mispredicts increments on each cycle with mispredict=1.
  - Both wrap modulo 2**32 and update in the same edge as the table.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then if_pc=0x40 -> if_pred_taken=0; counter[16]=01.
- Resolution sweep: ex_branch=1, func3=000, zf=1, ex_pred_taken=0 -> take_branch=1, mispredict=1. Repeat all six legal func3 values with flags set and cleared -> expected take per encoding.
- Training: four taken resolutions at ex_pc=0x100 -> counter[0] goes 01→10→11→11 (saturates). if_pc=0x100 predicts 1 from the cycle after the first update. Three not-taken resolutions -> 10, 01, 00, then stays 00.
- Same-cycle hazard: EX resolves taken at 0x100 (counter 01) while if_pc=0x100 -> if_pred_taken=0 that cycle, 1 the next.
- Illegal func3=010 with ex_pred_taken=1 -> take_branch=0, mispredict=1, counter unchanged. Non-branch with ex_pred_taken=1 -> mispredict=1, no update.
- With BPU_STATS_EN: 10 branches including 3 mispredicts, plus rst asserted during an update -> counters read 10/3 before rst, 0/0 after rst; the table entry is unchanged by the discarded update.
